// File: rtl/dice_round_display_pkg.sv
// Shared types for the dice round display: face width, pattern codes, FSM states
// and the legal-face test used by the capture logic.
package dice_round_display_pkg;

  localparam int FACE_W = 3;

  typedef logic [FACE_W-1:0] face_t;

  typedef enum logic [1:0] {
    PAT_NORMAL    = 2'b00,
    PAT_PASCH     = 2'b01,
    PAT_THREE     = 2'b10,
    PAT_SPECIAL21 = 2'b11
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_RESULT  = 2'b10
  } state_e;

  // A die can only show 1..6; the 3-bit codes 0 and 7 mark a faulty roller.
  function automatic logic face_legal(input face_t f);
    return (f != 3'd0) && (f != 3'd7);
  endfunction

endpackage

// File: rtl/dice_round_display_classify.sv
// Combinational round classifier: enabled faces -> display digit, pattern code and
// unsaturated sum. Priority: SPECIAL21, PASCH, THREE, NORMAL.
module dice_round_display_classify
  import dice_round_display_pkg::*;
#(
  parameter int NUM_DICE = 2,
  parameter int SUM_W    = 5
) (
  input  logic [NUM_DICE*FACE_W-1:0] faces,
  input  logic [NUM_DICE-1:0]        mask,
  output logic [3:0]                 digit,
  output pattern_e                   pattern,
  output logic [SUM_W-1:0]           sum
);

  face_t            face_v;
  face_t            ref_face;
  face_t            f0;
  face_t            f1;
  logic             have_ref;
  logic             all_equal;
  logic             has_three;
  logic             special;
  logic [2:0]       n_en;
  logic [SUM_W-1:0] sum_v;
  logic [3:0]       sum_sat;

  // NOTE: every signal assigned in an always_comb gets a default at the top of the
  // block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    sum_v     = '0;
    n_en      = '0;
    has_three = 1'b0;
    all_equal = 1'b1;
    have_ref  = 1'b0;
    ref_face  = '0;
    face_v    = '0;
    for (int i = 0; i < NUM_DICE; i++) begin
      face_v = faces[i*FACE_W +: FACE_W];
      if (mask[i]) begin
        sum_v = sum_v + SUM_W'(face_v);
        n_en  = n_en + 3'd1;
        if (face_v == 3'd3) has_three = 1'b1;
        if (!have_ref) begin
          ref_face = face_v;
          have_ref = 1'b1;
        end else if (face_v != ref_face) begin
          all_equal = 1'b0;
        end
      end
    end
  end

  assign f0      = faces[FACE_W-1:0];
  assign f1      = faces[2*FACE_W-1:FACE_W];
  // The 1+2 combination only exists in the two-player game with both dice in play.
  assign special = (NUM_DICE == 2) && (&mask) &&
                   (((f0 == 3'd1) && (f1 == 3'd2)) || ((f0 == 3'd2) && (f1 == 3'd1)));
  assign sum_sat = (sum_v > SUM_W'(15)) ? 4'd15 : sum_v[3:0];

  always_comb begin
    digit   = sum_sat;
    pattern = PAT_NORMAL;
    if (special) begin
      digit   = 4'd3;
      pattern = PAT_SPECIAL21;
    end else if ((n_en >= 3'd2) && all_equal) begin
      digit   = {1'b0, ref_face};
      pattern = PAT_PASCH;
    end else if (has_three) begin
      pattern = PAT_THREE;
    end
  end

  assign sum = sum_v;

endmodule

// File: rtl/dice_round_display.sv
// Round collector for NUM_DICE dice rollers: latches one roll per enabled channel,
// classifies the completed round and holds digit/pattern/sum for the display driver.
module dice_round_display
  import dice_round_display_pkg::*;
#(
  parameter int NUM_DICE       = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SUM_W          = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_DICE-1:0]        die_en,
  input  logic [FACE_W*NUM_DICE-1:0] dice,
  input  logic [NUM_DICE-1:0]        rolled,
  input  logic                       clear,
  output logic [3:0]                 digit,
  output logic [1:0]                 pattern,
  output logic [SUM_W-1:0]           sum,
  output logic                       result_valid,
  output logic                       busy,
  output logic                       round_abort,
  output logic [7:0]                 round_cnt,
  output logic                       face_err
);

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int TIMER_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST =
    TIMEOUT_EN ? TIMER_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e                           state_q, state_d;
  logic [NUM_DICE-1:0]              en_lat_q, en_lat_d;
  logic [NUM_DICE-1:0]              got_q, got_d;
  logic [NUM_DICE-1:0][FACE_W-1:0]  faces_q, faces_d;
  logic [TIMER_W-1:0]               timer_q, timer_d;
  logic                             abort_d;

  logic [3:0]                       digit_q;
  pattern_e                         pattern_q;
  logic [SUM_W-1:0]                 sum_q;
  logic                             result_valid_q;
  logic                             round_abort_q;
  logic [7:0]                       round_cnt_q;
  logic                             face_err_q;

  logic [NUM_DICE-1:0]              en_eff;
  logic [NUM_DICE-1:0]              accept;
  logic [NUM_DICE-1:0]              bad_face;
  logic [NUM_DICE-1:0]              got_or;

  logic [3:0]                       cls_digit;
  pattern_e                         cls_pattern;
  logic [SUM_W-1:0]                 cls_sum;

  // In IDLE a round has not started, so the live enables decide; afterwards the
  // enables latched at the first roll stay in force until the round ends.
  assign en_eff = (state_q == ST_IDLE) ? die_en : en_lat_q;
  assign got_or = got_q | accept;

  always_comb begin
    accept   = '0;
    bad_face = '0;
    faces_d  = faces_q;
    for (int i = 0; i < NUM_DICE; i++) begin
      if (rolled[i] && en_eff[i] && (state_q != ST_RESULT)) begin
        if (face_legal(dice[i*FACE_W +: FACE_W])) begin
          accept[i]  = 1'b1;
          faces_d[i] = dice[i*FACE_W +: FACE_W];
        end else begin
          bad_face[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    en_lat_d = en_lat_q;
    got_d    = got_q;
    timer_d  = timer_q;
    abort_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|accept) begin
          en_lat_d = die_en;
          got_d    = accept;
          timer_d  = '0;
          state_d  = (accept == die_en) ? ST_RESULT : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (clear) begin
          state_d = ST_IDLE;
          got_d   = '0;
          abort_d = 1'b1;
        end else if (got_or == en_lat_q) begin
          // Completion is checked before timeout so a last-moment roll still counts.
          state_d = ST_RESULT;
          got_d   = got_or;
        end else if (TIMEOUT_EN && (timer_q == TIMER_LAST)) begin
          state_d = ST_IDLE;
          got_d   = '0;
          abort_d = 1'b1;
        end else begin
          got_d   = got_or;
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_RESULT: begin
        state_d = ST_IDLE;
        got_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        got_d   = '0;
      end
    endcase
  end

  dice_round_display_classify #(
    .NUM_DICE (NUM_DICE),
    .SUM_W    (SUM_W)
  ) u_classify (
    .faces   (faces_q),
    .mask    (en_lat_q),
    .digit   (cls_digit),
    .pattern (cls_pattern),
    .sum     (cls_sum)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      en_lat_q <= '0;
      got_q    <= '0;
      faces_q  <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      en_lat_q <= en_lat_d;
      got_q    <= got_d;
      faces_q  <= faces_d;
      timer_q  <= timer_d;
    end
  end

  // Display registers load one cycle after the completing roll, from captured faces.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q        <= '0;
      pattern_q      <= PAT_NORMAL;
      sum_q          <= '0;
      result_valid_q <= 1'b0;
      round_abort_q  <= 1'b0;
      round_cnt_q    <= '0;
      face_err_q     <= 1'b0;
    end else begin
      result_valid_q <= (state_q == ST_RESULT);
      round_abort_q  <= abort_d;
      face_err_q     <= face_err_q | (|bad_face);
      if (state_q == ST_RESULT) begin
        digit_q     <= cls_digit;
        pattern_q   <= cls_pattern;
        sum_q       <= cls_sum;
        round_cnt_q <= round_cnt_q + 8'd1;
      end
    end
  end

  assign digit        = digit_q;
  assign pattern      = pattern_q;
  assign sum          = sum_q;
  assign result_valid = result_valid_q;
  assign busy         = (state_q != ST_IDLE);
  assign round_abort  = round_abort_q;
  assign round_cnt    = round_cnt_q;
  assign face_err     = face_err_q;

endmodule

// File: tb/tb_dice_round_display.sv
// Bench for dice_round_display: a 2-die and a 4-die instance driven by directed
// sequences, a classification table and random traffic against a behavioural model.
module tb_dice_round_display;

  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  en2, rolled2;
  logic [5:0]  dice2;
  logic        clear2;
  logic [3:0]  digit2;
  logic [1:0]  pat2;
  logic [4:0]  sum2;
  logic        rv2, busy2, ab2, fe2;
  logic [7:0]  rc2;

  logic [3:0]  en4, rolled4;
  logic [11:0] dice4;
  logic        clear4;
  logic [3:0]  digit4;
  logic [1:0]  pat4;
  logic [4:0]  sum4;
  logic        rv4, busy4, ab4, fe4;
  logic [7:0]  rc4;

  dice_round_display #(.NUM_DICE(2), .TIMEOUT_CYCLES(TO), .SUM_W(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .die_en(en2), .dice(dice2), .rolled(rolled2), .clear(clear2),
    .digit(digit2), .pattern(pat2), .sum(sum2), .result_valid(rv2), .busy(busy2),
    .round_abort(ab2), .round_cnt(rc2), .face_err(fe2));

  dice_round_display #(.NUM_DICE(4), .TIMEOUT_CYCLES(TO), .SUM_W(5)) dut4 (
    .clk(clk), .rst_n(rst_n), .die_en(en4), .dice(dice4), .rolled(rolled4), .clear(clear4),
    .digit(digit4), .pattern(pat4), .sum(sum4), .result_valid(rv4), .busy(busy4),
    .round_abort(ab4), .round_cnt(rc4), .face_err(fe4));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    bit        active;   // partial round in progress
    bit        pending;  // round complete, result shows next edge
    bit [3:0]  en_lat;
    bit [3:0]  got;
    bit [11:0] face;
    int        start;    // cycle of the first accepted roll
    bit [3:0]  digit;
    bit [1:0]  pat;
    bit [4:0]  sum;
    bit        rv;
    bit        ab;
    bit [7:0]  rc;
    bit        fe;
  } model_t;

  model_t m [2];

  task automatic ref_classify(input int n, input bit [3:0] mask, input bit [11:0] fv,
                              output int d, output int p, output int s);
    int q[$];
    bit same;
    bit three;
    q = {};
    for (int i = 0; i < n; i++) if (mask[i]) q.push_back(int'(fv[3*i +: 3]));
    s = 0;
    same = 1'b1;
    three = 1'b0;
    foreach (q[j]) begin
      s += q[j];
      if (q[j] != q[0]) same = 1'b0;
      if (q[j] == 3) three = 1'b1;
    end
    if (n == 2 && q.size() == 2 && ((q[0] == 1 && q[1] == 2) || (q[0] == 2 && q[1] == 1))) begin
      d = 3; p = 3;
    end else if (q.size() >= 2 && same) begin
      d = q[0]; p = 1;
    end else begin
      d = (s > 15) ? 15 : s;
      p = three ? 2 : 0;
    end
  endtask

  task automatic model_step(input int k, input int n, input bit [3:0] en, input bit [3:0] rl,
                            input bit [11:0] dv, input bit clr);
    model_t s, x;
    bit [3:0] live, acc;
    int d, p, sm, f;
    s = m[k];
    x = s;
    x.rv = 1'b0;
    x.ab = 1'b0;
    live = en & 4'((1 << n) - 1);
    if (s.pending) begin
      ref_classify(n, s.en_lat, s.face, d, p, sm);
      x.digit = 4'(d);
      x.pat = 2'(p);
      x.sum = 5'(sm);
      x.rv = 1'b1;
      x.rc = s.rc + 8'd1;
      x.pending = 1'b0;
      x.got = '0;
    end else begin
      acc = '0;
      for (int i = 0; i < n; i++) begin
        f = int'(dv[3*i +: 3]);
        if (rl[i] && (s.active ? s.en_lat[i] : live[i])) begin
          if (f >= 1 && f <= 6) begin
            acc[i] = 1'b1;
            x.face[3*i +: 3] = dv[3*i +: 3];
          end else begin
            x.fe = 1'b1;
          end
        end
      end
      if (!s.active) begin
        if (acc != 0) begin
          x.en_lat = live;
          x.got = acc;
          x.start = cyc;
          if (acc == live) x.pending = 1'b1;
          else x.active = 1'b1;
        end
      end else if (clr) begin
        x.active = 1'b0; x.ab = 1'b1; x.got = '0;
      end else begin
        x.got = s.got | acc;
        if (x.got == s.en_lat) begin
          x.active = 1'b0; x.pending = 1'b1;
        end else if (TO > 0 && cyc - s.start == TO) begin
          x.active = 1'b0; x.ab = 1'b1; x.got = '0;
        end
      end
    end
    m[k] = x;
  endtask

  function automatic logic [22:0] exp_vec(input int k);
    return {m[k].digit, m[k].pat, m[k].sum, m[k].rv, (m[k].active | m[k].pending),
            m[k].ab, m[k].rc, m[k].fe};
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step(0, 2, {2'b00, en2}, {2'b00, rolled2}, {6'b0, dice2}, clear2);
    model_step(1, 4, en4, rolled4, dice4, clear4);
    #1;
    check("dut2_vs_model", 32'({digit2, pat2, sum2, rv2, busy2, ab2, rc2, fe2}), 32'(exp_vec(0)));
    check("dut4_vs_model", 32'({digit4, pat4, sum4, rv4, busy4, ab4, rc4, fe4}), 32'(exp_vec(1)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rolled2 = '0; rolled4 = '0; clear2 = 1'b0; clear4 = 1'b0;
    m[0] = '0;
    m[1] = '0;
    #2;
    check("reset_dut2", 32'({digit2, pat2, sum2, rv2, busy2, ab2, rc2, fe2}), 32'd0);
    check("reset_dut4", 32'({digit4, pat4, sum4, rv4, busy4, ab4, rc4, fe4}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic bit [11:0] mk(input int f3, input int f2, input int f1, input int f0);
    return {3'(f3), 3'(f2), 3'(f1), 3'(f0)};
  endfunction

  function automatic bit [2:0] rnd_face();
    if ($urandom_range(0, 15) == 0) return ($urandom_range(0, 1) == 1) ? 3'd7 : 3'd0;
    return 3'($urandom_range(1, 6));
  endfunction

  typedef struct packed {
    bit        is4;
    bit [3:0]  en;
    bit [3:0]  rl;
    bit [11:0] faces;
    bit [3:0]  digit;
    bit [1:0]  pat;
    bit [4:0]  sum;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [11:0] act;
    int rate;

    tbl[0]  = '{1'b0, 4'b0011, 4'b0011, mk(0, 0, 2, 1), 4'd3,  2'd3, 5'd3};
    tbl[1]  = '{1'b0, 4'b0011, 4'b0011, mk(0, 0, 1, 2), 4'd3,  2'd3, 5'd3};
    tbl[2]  = '{1'b0, 4'b0011, 4'b0011, mk(0, 0, 4, 4), 4'd4,  2'd1, 5'd8};
    tbl[3]  = '{1'b0, 4'b0011, 4'b0011, mk(0, 0, 5, 3), 4'd8,  2'd2, 5'd8};
    tbl[4]  = '{1'b0, 4'b0011, 4'b0011, mk(0, 0, 5, 6), 4'd11, 2'd0, 5'd11};
    tbl[5]  = '{1'b0, 4'b0001, 4'b0001, mk(0, 0, 0, 5), 4'd5,  2'd0, 5'd5};
    tbl[6]  = '{1'b0, 4'b0010, 4'b0010, mk(0, 0, 3, 0), 4'd3,  2'd2, 5'd3};
    tbl[7]  = '{1'b0, 4'b0001, 4'b0011, mk(0, 0, 2, 1), 4'd1,  2'd0, 5'd1};
    tbl[8]  = '{1'b1, 4'b1011, 4'b1111, mk(6, 2, 6, 6), 4'd6,  2'd1, 5'd18};
    tbl[9]  = '{1'b1, 4'b1011, 4'b1111, mk(6, 2, 5, 6), 4'd15, 2'd0, 5'd17};
    tbl[10] = '{1'b1, 4'b1111, 4'b1111, mk(6, 6, 6, 6), 4'd6,  2'd1, 5'd24};
    tbl[11] = '{1'b1, 4'b1111, 4'b1111, mk(4, 3, 2, 1), 4'd10, 2'd2, 5'd10};
    tbl[12] = '{1'b1, 4'b0011, 4'b0011, mk(0, 0, 2, 1), 4'd3,  2'd0, 5'd3};
    tbl[13] = '{1'b1, 4'b1111, 4'b1111, mk(5, 6, 6, 6), 4'd15, 2'd0, 5'd23};
    tbl[14] = '{1'b0, 4'b0011, 4'b0011, mk(0, 0, 3, 3), 4'd3,  2'd1, 5'd6};

    en2 = 2'b11; rolled2 = '0; dice2 = '0; clear2 = 1'b0;
    en4 = 4'b1111; rolled4 = '0; dice4 = '0; clear4 = 1'b0;
    #1;
    do_reset();

    // single roll only: round stays open, display untouched
    dice2 = {3'd0, 3'd4}; rolled2 = 2'b01;
    tick();
    check("t1_busy", 32'(busy2), 32'd1);
    check("t1_rv", 32'(rv2), 32'd0);
    check("t1_digit", 32'(digit2), 32'd0);
    rolled2 = '0;
    tick(); tick();

    // completing roll: result one edge later, pulse one cycle wide
    dice2 = {3'd4, 3'd0}; rolled2 = 2'b10;
    tick();
    check("t2_rv_at_E", 32'(rv2), 32'd0);
    check("t2_busy_at_E", 32'(busy2), 32'd1);
    rolled2 = '0;
    tick();
    check("t2_rv", 32'(rv2), 32'd1);
    check("t2_pattern", 32'(pat2), 32'd1);
    check("t2_digit", 32'(digit2), 32'd4);
    check("t2_sum", 32'(sum2), 32'd8);
    check("t2_round_cnt", 32'(rc2), 32'd1);
    tick();
    check("t2_rv_fall", 32'(rv2), 32'd0);
    check("t2_idle", 32'(busy2), 32'd0);

    // re-roll overwrites, then THREE
    dice2 = {3'd6, 3'd0}; rolled2 = 2'b10; tick();
    dice2 = {3'd2, 3'd0}; rolled2 = 2'b10; tick();
    dice2 = {3'd2, 3'd3}; rolled2 = 2'b01; tick();
    rolled2 = '0; tick();
    check("t3_pattern", 32'(pat2), 32'd2);
    check("t3_digit", 32'(digit2), 32'd5);
    check("t3_sum", 32'(sum2), 32'd5);
    tick();
    dice2 = {3'd2, 3'd1}; rolled2 = 2'b11; tick();
    rolled2 = '0; tick();
    check("t3_special_pat", 32'(pat2), 32'd3);
    check("t3_special_digit", 32'(digit2), 32'd3);
    check("t3_round_cnt", 32'(rc2), 32'd3);
    tick();

    // timeout after TO cycles, display holds
    dice2 = {3'd0, 3'd5}; rolled2 = 2'b01; tick();
    rolled2 = '0;
    repeat (TO - 1) tick();
    check("t4_no_abort_yet", 32'({busy2, ab2}), 32'b10);
    tick();
    check("t4_abort", 32'(ab2), 32'd1);
    check("t4_busy", 32'(busy2), 32'd0);
    check("t4_hold", 32'({digit2, pat2, sum2}), 32'({4'd3, 2'd3, 5'd3}));
    tick();
    check("t4_abort_fall", 32'(ab2), 32'd0);

    // completion on the timeout edge wins
    dice2 = {3'd0, 3'd5}; rolled2 = 2'b01; tick();
    rolled2 = '0;
    repeat (TO - 1) tick();
    dice2 = {3'd5, 3'd5}; rolled2 = 2'b10; tick();
    check("t4_edge_no_abort", 32'({busy2, ab2}), 32'b10);
    rolled2 = '0; tick();
    check("t4_edge_result", 32'({rv2, pat2, digit2, sum2}), 32'({1'b1, 2'd1, 4'd5, 5'd10}));
    tick();

    // clear beats a same-cycle completing roll; clear in IDLE is inert
    dice2 = {3'd0, 3'd2}; rolled2 = 2'b01; tick();
    dice2 = {3'd6, 3'd2}; rolled2 = 2'b10; clear2 = 1'b1; tick();
    check("t4_clear_abort", 32'({ab2, busy2}), 32'b10);
    rolled2 = '0; clear2 = 1'b0; tick();
    check("t4_clear_no_result", 32'({rv2, digit2}), 32'({1'b0, 4'd5}));
    clear2 = 1'b1; tick();
    check("t4_clear_idle", 32'(ab2), 32'd0);
    clear2 = 1'b0;

    // illegal face is ignored but flagged
    dice2 = {3'd0, 3'd7}; rolled2 = 2'b01; tick();
    check("t5_face_err", 32'({fe2, busy2}), 32'b10);
    rolled2 = '0; tick();

    // no channels enabled: nothing starts
    en2 = 2'b00; dice2 = {3'd4, 3'd4}; rolled2 = 2'b11; tick();
    check("t5_no_en", 32'(busy2), 32'd0);
    rolled2 = '0; en2 = 2'b11;

    // disabled channel 2 on the 4-die instance is ignored
    en4 = 4'b1011; dice4 = mk(0, 5, 0, 0); rolled4 = 4'b0100; tick();
    check("t6_ch2_ignored", 32'(busy4), 32'd0);
    rolled4 = '0;

    // reset in the middle of a round
    dice2 = {3'd0, 3'd4}; rolled2 = 2'b01; tick();
    rolled2 = '0;
    check("t5_pre_reset_busy", 32'(busy2), 32'd1);
    do_reset();

    for (int v = 0; v < 15; v++) begin
      if (tbl[v].is4) begin
        en4 = tbl[v].en; dice4 = tbl[v].faces; rolled4 = tbl[v].rl;
      end else begin
        en2 = tbl[v].en[1:0]; dice2 = tbl[v].faces[5:0]; rolled2 = tbl[v].rl[1:0];
      end
      tick();
      rolled2 = '0; rolled4 = '0;
      tick();
      act = tbl[v].is4 ? {rv4, digit4, pat4, sum4} : {rv2, digit2, pat2, sum2};
      check($sformatf("table_%0d", v), 32'(act),
            32'({1'b1, tbl[v].digit, tbl[v].pat, tbl[v].sum}));
      tick();
    end

    // random traffic, alternating busy and sparse roll rates
    en2 = 2'b11; en4 = 4'b1111;
    rate = 5;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) rate = (rate == 5) ? 40 : 5;
      if ($urandom_range(0, 29) == 0) en2 = 2'($urandom);
      if ($urandom_range(0, 29) == 0) en4 = 4'($urandom);
      for (int i = 0; i < 2; i++) begin
        rolled2[i] = ($urandom_range(0, rate) == 0);
        dice2[3*i +: 3] = rnd_face();
      end
      for (int i = 0; i < 4; i++) begin
        rolled4[i] = ($urandom_range(0, rate) == 0);
        dice4[3*i +: 3] = rnd_face();
      end
      clear2 = ($urandom_range(0, 59) == 0);
      clear4 = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
